// File: rtl/sprite_palette_pkg.sv
// Shared types and reset contents for the sprite palette bank.
package sprite_palette_pkg;

  // 12-bit colour, {R[3:0], G[3:0], B[3:0]}
  typedef logic [11:0] rgb12_t;

  // Hit-flash sequencer states
  typedef enum logic [1:0] {
    FLASH_IDLE = 2'd0,
    FLASH_ON   = 2'd1,
    FLASH_OFF  = 2'd2
  } flash_state_e;

  localparam int DEFAULT_PAL_LEN = 8;

  // Colours every palette is loaded with on reset
  localparam rgb12_t DEFAULT_PAL [DEFAULT_PAL_LEN] = '{
    12'h0E0, 12'h444, 12'hDBB, 12'h000,
    12'h080, 12'hC20, 12'h977, 12'h610
  };

  // Reset value of palette entry idx: the default table, zero-padded past its end
  function automatic rgb12_t default_entry(input int idx);
    rgb12_t val;
    val = '0;
    if (idx >= 0 && idx < DEFAULT_PAL_LEN) begin
      val = DEFAULT_PAL[idx[2:0]];
    end
    return val;
  endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// Frame-timed hit-flash sequencer: alternates ON/OFF on every frame_tick
// for FLASH_FRAMES ticks after flash_start, then returns to idle.
module palette_flash_fsm
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_tick,
  input  logic         flash_start,
  output logic         flash_on,
  output logic         flash_busy,
  output flash_state_e state_dbg
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  localparam logic [1:0] ST_IDLE = FLASH_IDLE;
  localparam logic [1:0] ST_ON   = FLASH_ON;
  localparam logic [1:0] ST_OFF  = FLASH_OFF;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  // Next state: a start (or restart) always wins over a frame tick
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (flash_start) begin
      state_d     = ST_ON;
      remaining_d = RELOAD;
    end else if (frame_tick) begin
      case (state_q)
        ST_ON, ST_OFF: begin
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end
      endcase
    end else if (state_q != ST_IDLE && state_q != ST_ON && state_q != ST_OFF) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
    end
  end

  // State and frame counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  assign flash_on   = (state_q == ST_ON);
  assign flash_busy = (state_q == ST_ON) || (state_q == ST_OFF);
  assign state_dbg  = flash_state_e'(state_q);

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-palette, run-time-writable sprite colour lookup with a one-cycle
// registered read, chroma-key transparency and a frame-timed hit flash.
//
// Handshake: a lookup is issued by holding rd_valid high for one cycle with
// rd_pal/rd_index; exactly one cycle later out_valid is high for one cycle
// with the result. There is no back-pressure. When out_valid is low the
// colour and transparent outputs keep the last looked-up result.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int          NUM_PAL      = 4,
  parameter int          DEPTH        = 8,
  parameter int          TRANSP_IDX   = 0,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [11:0] FLASH_RGB    = 12'hFFF,
  localparam int         PAL_W        = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
  localparam int         IDX_W        = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic             rd_valid,
  input  logic [PAL_W-1:0] rd_pal,
  input  logic [IDX_W-1:0] rd_index,
  input  logic             wr_en,
  input  logic [PAL_W-1:0] wr_pal,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [11:0]      wr_rgb,
  input  logic             flash_start,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             out_valid,
  output logic             transparent,
  output logic             flash_busy
);

  rgb12_t pal_q [NUM_PAL][DEPTH];
  rgb12_t pal_d [NUM_PAL][DEPTH];

  rgb12_t rgb_q, rgb_d;
  logic   out_valid_q, out_valid_d;
  logic   transparent_q, transparent_d;

  logic         flash_on;
  flash_state_e flash_state;
  logic         rd_pal_ok;
  rgb12_t       rd_entry;

  palette_flash_fsm #(
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_flash (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .flash_start (flash_start),
    .flash_on    (flash_on),
    .flash_busy  (flash_busy),
    .state_dbg   (flash_state)
  );

  // Busy must track the sequencer state exactly
  always_comb begin
    if (!Reset) begin
      assert (flash_busy == (flash_state != FLASH_IDLE));
    end
  end

  // Palette write: out-of-range palettes match no row and are dropped
  always_comb begin
    pal_d = pal_q;
    for (int p = 0; p < NUM_PAL; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_pal == PAL_W'(p) && wr_index == IDX_W'(i)) begin
          pal_d[p][i] = wr_rgb;
        end
      end
    end
  end

  // Palette storage; reset reloads the default colours into every palette
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          pal_q[p][i] <= default_entry(i);
        end
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  // Read port sees the pre-write contents (read-before-write)
  always_comb begin
    rd_pal_ok = (32'(rd_pal) < 32'(NUM_PAL));
    rd_entry  = '0;
    for (int p = 0; p < NUM_PAL; p++) begin
      if (rd_pal == PAL_W'(p)) begin
        rd_entry = pal_q[p][rd_index];
      end
    end
  end

  // Output stage: key/invalid-palette detection and flash override
  always_comb begin
    rgb_d         = rgb_q;
    transparent_d = transparent_q;
    out_valid_d   = rd_valid;
    if (rd_valid) begin
      if (!rd_pal_ok) begin
        rgb_d         = '0;
        transparent_d = 1'b1;
      end else begin
        transparent_d = (rd_index == IDX_W'(TRANSP_IDX));
        rgb_d         = (flash_on && !transparent_d) ? FLASH_RGB : rd_entry;
      end
    end
  end

  // Output pipeline registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q         <= '0;
      out_valid_q   <= 1'b0;
      transparent_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      out_valid_q   <= out_valid_d;
      transparent_q <= transparent_d;
    end
  end

  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign out_valid   = out_valid_q;
  assign transparent = transparent_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Bench for sprite_palette_bank. NUM_PAL is set to 5 so that a 3-bit palette
// select can address non-existent palettes 5..7.
module tb_sprite_palette_bank;

  localparam int NUM_PAL      = 5;
  localparam int DEPTH        = 8;
  localparam int TRANSP_IDX   = 0;
  localparam int FLASH_FRAMES = 8;
  localparam int PAL_W        = 3;
  localparam int IDX_W        = 3;
  localparam int W            = 13;  // {transparent, rgb[11:0]}

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             frame_tick = 1'b0;
  logic             rd_valid = 1'b0;
  logic [PAL_W-1:0] rd_pal = '0;
  logic [IDX_W-1:0] rd_index = '0;
  logic             wr_en = 1'b0;
  logic [PAL_W-1:0] wr_pal = '0;
  logic [IDX_W-1:0] wr_index = '0;
  logic [11:0]      wr_rgb = '0;
  logic             flash_start = 1'b0;
  logic [3:0]       red, green, blue;
  logic             out_valid, transparent, flash_busy;

  sprite_palette_bank #(
    .NUM_PAL      (NUM_PAL),
    .DEPTH        (DEPTH),
    .TRANSP_IDX   (TRANSP_IDX),
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_RGB    (12'hFFF)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .rd_valid    (rd_valid),
    .rd_pal      (rd_pal),
    .rd_index    (rd_index),
    .wr_en       (wr_en),
    .wr_pal      (wr_pal),
    .wr_index    (wr_index),
    .wr_rgb      (wr_rgb),
    .flash_start (flash_start),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .out_valid   (out_valid),
    .transparent (transparent),
    .flash_busy  (flash_busy)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  logic [11:0]  mdl_pal [NUM_PAL][DEPTH];
  bit           mdl_active;
  int           mdl_frames;   // frame ticks seen since the flash (re)started
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int           checks = 0;
  int           failures = 0;

  function automatic void mdl_reset();
    logic [11:0] defaults [8];
    defaults = '{12'h0E0, 12'h444, 12'hDBB, 12'h000, 12'h080, 12'hC20, 12'h977, 12'h610};
    for (int p = 0; p < NUM_PAL; p++)
      for (int i = 0; i < DEPTH; i++)
        mdl_pal[p][i] = (i < 8) ? defaults[i] : 12'h000;
    mdl_active = 0;
    mdl_frames = 0;
  endfunction

  // Flash is visible on the even-numbered frames of an active sequence
  function automatic logic [W-1:0] mdl_lookup(input int p, input int idx);
    bit key;
    bit on;
    if (p >= NUM_PAL) return {1'b1, 12'h000};
    key = (idx == TRANSP_IDX);
    on  = mdl_active && (mdl_frames % 2 == 0);
    if (!key && on) return {1'b0, 12'hFFF};
    return {key, mdl_pal[p][idx]};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rv, input int rp, input int ri,
                      input logic we, input int wp, input int wi, input logic [11:0] wrgb,
                      input logic fs, input logic ft);
    checks++;
    if (flash_busy !== mdl_active) begin
      failures++;
      $display("FAIL flash_busy got=%0b exp=%0b t=%0t", flash_busy, mdl_active, $time);
    end
    rd_valid    = rv;
    rd_pal      = PAL_W'(rp);
    rd_index    = IDX_W'(ri);
    wr_en       = we;
    wr_pal      = PAL_W'(wp);
    wr_index    = IDX_W'(wi);
    wr_rgb      = wrgb;
    flash_start = fs;
    frame_tick  = ft;
    if (rv) exp_q.push_back(mdl_lookup(rp, ri));
    if (we && wp < NUM_PAL) mdl_pal[wp][wi] = wrgb;
    if (fs) begin
      mdl_active = 1;
      mdl_frames = 0;
    end else if (ft && mdl_active) begin
      mdl_frames++;
      if (mdl_frames == FLASH_FRAMES) mdl_active = 0;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input int p, input int i);
    step(1'b1, p, i, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 0, 0, 1'b0, 0, 0, 12'h000, 1'b0, 1'b1);
  endtask

  task automatic idle_inputs();
    rd_valid = 0; wr_en = 0; flash_start = 0; frame_tick = 0;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    exp_q.delete();
    mdl_reset();
    #2;
    chk("reset_rgb", {4'h0, red, green, blue}, 16'h0000);
    chk("reset_out_valid", {15'h0, out_valid}, 16'h0000);
    chk("reset_transparent", {15'h0, transparent}, 16'h0000);
    chk("reset_flash_busy", {15'h0, flash_busy}, 16'h0000);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    if (Reset) begin
      last_exp = '0;
    end else if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid got=%h t=%0t", {transparent, red, green, blue}, $time);
      end else begin
        last_exp = exp_q.pop_front();
        if ({transparent, red, green, blue} !== last_exp) begin
          failures++;
          $display("FAIL lookup got=%h exp=%h t=%0t", {transparent, red, green, blue}, last_exp, $time);
        end
      end
    end else begin
      checks++;
      if ({transparent, red, green, blue} !== last_exp) begin
        failures++;
        $display("FAIL hold got=%h exp=%h t=%0t", {transparent, red, green, blue}, last_exp, $time);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    mdl_reset();
    last_exp = '0;
    @(posedge Clk);
    #1;
    do_reset();

    // Default contents, key index and invalid palettes
    rd(0, 1);
    rd(2, 0);
    rd(5, 3);
    rd(7, 1);
    rd(4, 7);

    // Read-before-write, then the new value; an invalid-palette write is dropped
    step(1'b1, 1, 3, 1'b1, 1, 3, 12'hABC, 1'b0, 1'b0);
    rd(1, 3);
    step(1'b0, 0, 0, 1'b1, 6, 3, 12'h123, 1'b0, 1'b0);
    rd(1, 3);
    rd(1, 0);

    // Full flash sequence with several pixels per frame
    step(1'b1, 0, 1, 1'b0, 0, 0, 12'h000, 1'b1, 1'b0);
    for (int f = 0; f < FLASH_FRAMES + 2; f++) begin
      rd(0, 2);
      rd(1, 0);
      rd($urandom_range(0, 7), $urandom_range(0, 7));
      tick();
    end

    // Restart after 3 ticks, then restart coinciding with a tick
    step(1'b0, 0, 0, 1'b0, 0, 0, 12'h000, 1'b1, 1'b0);
    repeat (3) begin
      rd(3, 5);
      tick();
    end
    step(1'b1, 3, 5, 1'b0, 0, 0, 12'h000, 1'b1, 1'b0);
    rd(3, 5);
    tick();
    step(1'b1, 3, 5, 1'b0, 0, 0, 12'h000, 1'b1, 1'b1);
    for (int f = 0; f < FLASH_FRAMES + 1; f++) begin
      rd(3, 5);
      tick();
    end

    // Reset in the middle of a flash discards writes
    step(1'b0, 0, 0, 1'b0, 0, 0, 12'h000, 1'b1, 1'b0);
    step(1'b1, 0, 2, 1'b1, 0, 2, 12'h321, 1'b0, 1'b0);
    rd(0, 2);
    tick();
    do_reset();
    rd(0, 2);
    rd(0, 2);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 7), $urandom_range(0, 7),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
           12'($urandom_range(0, 4095)),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0));
    end

    // Drain and confirm every issued lookup produced an output
    idle_inputs();
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_outputs got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
